fifo_flex: RTL and testbench

Parametrised successor to the team's first-word-fall-through FIFO, used for buffering between accelerator pipeline stages and the RISC-V bus interface. It adds the following:
- a live occupancy count;
- programmable almost-full and almost-empty flags;
- a synchronous flush;
- sticky overflow and underflow error flags that replace simulation-only error checks.

Data is a single-clock valid/ready stream with registered status outputs.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ram.sv | 25 ++
 rtl/fifo_flex.sv | 164 ++++++++++++++++
 tb/tb_fifo_flex.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the flexible FIFO family: width helper, parameter
// checks and the threshold defaults inherited from the original FIFO.
`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
`define FIFO_PARAM_CHECK(lbl, cond, msg) \
   if (!(cond)) begin : lbl \
      $error(msg); \
   end
`endif

package fifo_pkg;

   localparam int FIFO_AFULL_MARGIN   = 4;
   localparam int FIFO_AEMPTY_DEFAULT = 4;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

   function automatic int fifo_level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered 1-cycle read.
// The array itself is never reset.
module fifo_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 512,
   parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_flex.sv
// First-word-fall-through FIFO with occupancy count, programmable almost
// flags, synchronous flush and sticky overflow/underflow flags.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int FIFO_DEPTH    = 512,
   parameter int FIFO_SKID     = 0,
   parameter int AFULL_THRESH  = FIFO_DEPTH - FIFO_AFULL_MARGIN,
   parameter int AEMPTY_THRESH = FIFO_AEMPTY_DEFAULT
) (
   input  logic                             clkIn,
   input  logic                             rstIn,
   input  logic [DATA_WIDTH-1:0]            wrDataIn,
   input  logic                             wrValidIn,
   output logic                             wrReadyOut,
   output logic [DATA_WIDTH-1:0]            rdDataOut,
   output logic                             rdValidOut,
   input  logic                             rdReadyIn,
   input  logic                             flushIn,
   input  logic                             clrFlagsIn,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  levelOut,
   output logic                             almostFullOut,
   output logic                             almostEmptyOut,
   output logic                             overflowOut,
   output logic                             underflowOut
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = fifo_level_width(FIFO_DEPTH);

   `FIFO_PARAM_CHECK(g_chk_width, DATA_WIDTH >= 1, "fifo_flex: DATA_WIDTH must be >= 1")
   `FIFO_PARAM_CHECK(g_chk_depth, (FIFO_DEPTH >= 4) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0),
                     "fifo_flex: FIFO_DEPTH must be a power of two >= 4")
   `FIFO_PARAM_CHECK(g_chk_skid, (FIFO_SKID >= 0) && (FIFO_SKID < FIFO_DEPTH),
                     "fifo_flex: FIFO_SKID out of range")
   `FIFO_PARAM_CHECK(g_chk_afull, (AFULL_THRESH >= 0) && (AFULL_THRESH <= FIFO_DEPTH),
                     "fifo_flex: AFULL_THRESH out of range")
   `FIFO_PARAM_CHECK(g_chk_aempty, (AEMPTY_THRESH >= 0) && (AEMPTY_THRESH <= FIFO_DEPTH),
                     "fifo_flex: AEMPTY_THRESH out of range")

   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] READY_L  = LW'(FIFO_DEPTH - FIFO_SKID);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);

   logic                  up;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         rd_ptr_nxt;
   logic [AW-1:0]         ram_raddr;
   logic [LW-1:0]         count;
   logic [LW-1:0]         count_nxt;
   logic [DATA_WIDTH-1:0] ram_q;
   logic [DATA_WIDTH-1:0] byp;
   logic                  byp_sel;
   logic [DATA_WIDTH-1:0] next_word;
   logic                  rd_en;
   logic                  room;
   logic                  wr_en;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ovf_evt;
   logic                  unf_evt;
   fifo_err_t             err;

   always_comb begin
      rd_en   = rdReadyIn & rdValidOut;
      room    = (count < DEPTH_L) | rd_en;
      wr_en   = wrValidIn & up & room;
      wr_acc  = wr_en & ~flushIn;
      rd_acc  = rd_en & ~flushIn;
      ovf_evt = wrValidIn & up & ~room & ~flushIn;
      unf_evt = rdReadyIn & ~rdValidOut & ~flushIn;

      count_nxt = count;
      if (flushIn) begin
         count_nxt = '0;
      end else if (wr_acc && !rd_acc) begin
         count_nxt = count + LW'(1);
      end else if (!wr_acc && rd_acc) begin
         count_nxt = count - LW'(1);
      end

      rd_ptr_nxt = rd_ptr;
      if (flushIn) begin
         rd_ptr_nxt = '0;
      end else if (rd_acc) begin
         rd_ptr_nxt = rd_ptr + AW'(1);
      end

      // The RAM always prefetches the word behind the next head, so a read
      // can promote it into rdDataOut on the very next edge.
      ram_raddr = rd_ptr_nxt + AW'(1);
      next_word = byp_sel ? byp : ram_q;
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (AW)
   ) u_ram (
      .clk     (clkIn),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (wrDataIn),
      .rd_addr (ram_raddr),
      .rd_data (ram_q)
   );

   // A word written on the same edge that its slot is read sees stale RAM
   // data, so it is captured here and selected instead for one cycle.
   always_ff @(posedge clkIn) begin
      byp <= wrDataIn;
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         up             <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         byp_sel        <= 1'b0;
         rdDataOut      <= '0;
         wrReadyOut     <= 1'b0;
         rdValidOut     <= 1'b0;
         almostFullOut  <= 1'b0;
         almostEmptyOut <= 1'b1;
         err            <= '0;
      end else begin
         up         <= 1'b1;
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         byp_sel    <= wr_acc & (wr_ptr == ram_raddr);
         if (flushIn) begin
            wr_ptr <= '0;
         end else if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end

         if (rd_acc) begin
            if (count >= LW'(2)) begin
               rdDataOut <= next_word;
            end else if (wr_acc) begin
               rdDataOut <= wrDataIn;
            end
         end else if (wr_acc && (count == '0)) begin
            rdDataOut <= wrDataIn;
         end

         wrReadyOut     <= count_nxt < READY_L;
         rdValidOut     <= count_nxt != '0;
         almostFullOut  <= count_nxt >= AFULL_L;
         almostEmptyOut <= count_nxt <= AEMPTY_L;
         err.overflow   <= (err.overflow & ~clrFlagsIn) | ovf_evt;
         err.underflow  <= (err.underflow & ~clrFlagsIn) | unf_evt;
      end
   end

   assign levelOut     = count;
   assign overflowOut  = err.overflow;
   assign underflowOut = err.underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// Scenario bench for fifo_flex against a queue-based reference model.
module tb_fifo_flex;

   localparam int DW = 8, DEPTH = 8, SKID = 2, AF = 6, AE = 1, LW = 4;

   logic          clkIn = 1'b0;
   logic          rstIn = 1'b1;
   logic [DW-1:0] wrDataIn = '0;
   logic          wrValidIn = 1'b0;
   logic          wrReadyOut;
   logic [DW-1:0] rdDataOut;
   logic          rdValidOut;
   logic          rdReadyIn = 1'b0;
   logic          flushIn = 1'b0;
   logic          clrFlagsIn = 1'b0;
   logic [LW-1:0] levelOut;
   logic          almostFullOut;
   logic          almostEmptyOut;
   logic          overflowOut;
   logic          underflowOut;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW-1:0] mq[$];
   bit m_ovf, m_unf, m_up;

   always #5 clkIn = ~clkIn;

   fifo_flex #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_SKID(SKID),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) dut (
      .clkIn(clkIn), .rstIn(rstIn), .wrDataIn(wrDataIn), .wrValidIn(wrValidIn),
      .wrReadyOut(wrReadyOut), .rdDataOut(rdDataOut), .rdValidOut(rdValidOut),
      .rdReadyIn(rdReadyIn), .flushIn(flushIn), .clrFlagsIn(clrFlagsIn),
      .levelOut(levelOut), .almostFullOut(almostFullOut), .almostEmptyOut(almostEmptyOut),
      .overflowOut(overflowOut), .underflowOut(underflowOut)
   );

   // One clock of stimulus, starting and ending at a falling edge; the model
   // follows the accept/flag rules directly on the queue.
   task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr,
                        input bit fl, input bit cf);
      bit rd, room, wr, ev_o, ev_u;
      wrValidIn = wv; wrDataIn = wd; rdReadyIn = rr; flushIn = fl; clrFlagsIn = cf;
      rd   = rr && (mq.size() != 0);
      room = (mq.size() < DEPTH) || rd;
      wr   = wv && m_up && room;
      ev_o = wv && m_up && !room && !fl;
      ev_u = rr && (mq.size() == 0) && !fl;
      @(posedge clkIn);
      if (fl) mq.delete();
      else begin
         if (rd) void'(mq.pop_front());
         if (wr) mq.push_back(wd);
      end
      m_ovf = (m_ovf && !cf) || ev_o;
      m_unf = (m_unf && !cf) || ev_u;
      m_up  = 1'b1;
      @(negedge clkIn);
      wrValidIn = 1'b0; rdReadyIn = 1'b0; flushIn = 1'b0; clrFlagsIn = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_up = 1'b0;
   endtask

   task automatic test_reset();
      rstIn = 1'b1; model_reset();
      @(negedge clkIn); @(negedge clkIn);
      tests_run++; if (wrReadyOut !== 1'b0) begin tests_failed++; $display("FAIL rst_wrready got %b want 0", wrReadyOut); end
      tests_run++; if (rdValidOut !== 1'b0) begin tests_failed++; $display("FAIL rst_rdvalid got %b want 0", rdValidOut); end
      tests_run++; if (rdDataOut !== 8'h00) begin tests_failed++; $display("FAIL rst_rddata got %h want 00", rdDataOut); end
      tests_run++; if (levelOut !== 4'd0) begin tests_failed++; $display("FAIL rst_level got %0d want 0", levelOut); end
      tests_run++; if ({almostFullOut, almostEmptyOut, overflowOut, underflowOut} !== 4'b0100) begin
         tests_failed++; $display("FAIL rst_flags got %b want 0100", {almostFullOut, almostEmptyOut, overflowOut, underflowOut}); end
      rstIn = 1'b0;
      // A write in the first cycle after release must be ignored.
      cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      tests_run++; if (wrReadyOut !== 1'b1) begin tests_failed++; $display("FAIL rst_ready_rise got %b want 1", wrReadyOut); end
      tests_run++; if (levelOut !== 4'd0) begin tests_failed++; $display("FAIL rst_first_write got level %0d want 0", levelOut); end
   endtask

   task automatic test_single_write();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      tests_run++; if (rdValidOut !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %b want 1", rdValidOut); end
      tests_run++; if (rdDataOut !== 8'hA5) begin tests_failed++; $display("FAIL single_data got %h want a5", rdDataOut); end
      tests_run++; if (levelOut !== 4'd1) begin tests_failed++; $display("FAIL single_level got %0d want 1", levelOut); end
      tests_run++; if (almostEmptyOut !== 1'b1) begin tests_failed++; $display("FAIL single_aempty got %b want 1", almostEmptyOut); end
   endtask

   task automatic test_fill_drain();
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         tests_run++; if (wrReadyOut !== (i + 1 < DEPTH - SKID)) begin
            tests_failed++; $display("FAIL fill_wrready after %0d writes got %b", i + 1, wrReadyOut); end
         tests_run++; if (almostFullOut !== (i + 1 >= AF)) begin
            tests_failed++; $display("FAIL fill_afull after %0d writes got %b", i + 1, almostFullOut); end
      end
      cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      tests_run++; if (overflowOut !== 1'b1) begin tests_failed++; $display("FAIL fill_overflow got %b want 1", overflowOut); end
      tests_run++; if (levelOut !== 4'd8) begin tests_failed++; $display("FAIL fill_level got %0d want 8", levelOut); end
      for (int i = 0; i < 8; i++) begin
         tests_run++; if (rdValidOut !== 1'b1 || rdDataOut !== 8'(i)) begin
            tests_failed++; $display("FAIL drain_data idx %0d got %h/%b want %h/1", i, rdDataOut, rdValidOut, 8'(i)); end
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      tests_run++; if (rdValidOut !== 1'b0 || levelOut !== 4'd0) begin
         tests_failed++; $display("FAIL drain_empty got valid %b level %0d want 0 0", rdValidOut, levelOut); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_level_one();
      cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
         tests_run++; if (rdDataOut !== 8'(8'h40 + i) || levelOut !== 4'd1 || rdValidOut !== 1'b1) begin
            tests_failed++; $display("FAIL lvl1_stream step %0d got %h lvl %0d want %h lvl 1", i, rdDataOut, levelOut, 8'(8'h40 + i)); end
      end
      tests_run++; if (overflowOut !== 1'b0 || underflowOut !== 1'b0) begin
         tests_failed++; $display("FAIL lvl1_flags got %b%b want 00", overflowOut, underflowOut); end
   endtask

   task automatic test_flush();
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
      tests_run++; if (levelOut !== 4'd0 || rdValidOut !== 1'b0 || wrReadyOut !== 1'b1) begin
         tests_failed++; $display("FAIL flush_state got lvl %0d valid %b ready %b want 0 0 1", levelOut, rdValidOut, wrReadyOut); end
      tests_run++; if (almostEmptyOut !== 1'b1 || almostFullOut !== 1'b0) begin
         tests_failed++; $display("FAIL flush_almost got ae %b af %b want 1 0", almostEmptyOut, almostFullOut); end
      cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      tests_run++; if (rdDataOut !== 8'h44 || levelOut !== 4'd1) begin
         tests_failed++; $display("FAIL flush_after got %h lvl %0d want 44 lvl 1", rdDataOut, levelOut); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_underflow();
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tests_run++; if (underflowOut !== 1'b1) begin tests_failed++; $display("FAIL unf_set got %b want 1", underflowOut); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      tests_run++; if (underflowOut !== 1'b1) begin tests_failed++; $display("FAIL unf_clr_race got %b want 1", underflowOut); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tests_run++; if (underflowOut !== 1'b0) begin tests_failed++; $display("FAIL unf_clear got %b want 0", underflowOut); end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hC8, 1'b1, 1'b0, 1'b0);
      tests_run++; if (levelOut !== 4'd8 || overflowOut !== 1'b0 || rdDataOut !== 8'hC1) begin
         tests_failed++; $display("FAIL full_rw got lvl %0d ovf %b data %h want 8 0 c1", levelOut, overflowOut, rdDataOut); end
      for (int i = 1; i <= 8; i++) begin
         tests_run++; if (rdDataOut !== 8'(8'hC0 + i)) begin
            tests_failed++; $display("FAIL full_rw_order idx %0d got %h want %h", i, rdDataOut, 8'(8'hC0 + i)); end
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < 45,
               $urandom_range(99) < 3, $urandom_range(99) < 5);
         tests_run++; if (levelOut !== LW'(mq.size()) || rdValidOut !== (mq.size() != 0)) begin
            tests_failed++; $display("FAIL rnd_level cyc %0d got %0d/%b want %0d", n, levelOut, rdValidOut, mq.size()); end
         if (mq.size() != 0) begin
            tests_run++; if (rdDataOut !== mq[0]) begin
               tests_failed++; $display("FAIL rnd_data cyc %0d got %h want %h", n, rdDataOut, mq[0]); end
         end
         tests_run++; if (wrReadyOut !== (mq.size() < DEPTH - SKID) || almostFullOut !== (mq.size() >= AF)
                          || almostEmptyOut !== (mq.size() <= AE)) begin
            tests_failed++; $display("FAIL rnd_status cyc %0d got rdy %b af %b ae %b lvl %0d", n,
                                     wrReadyOut, almostFullOut, almostEmptyOut, mq.size()); end
         tests_run++; if (overflowOut !== m_ovf || underflowOut !== m_unf) begin
            tests_failed++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", n, overflowOut, underflowOut, m_ovf, m_unf); end
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
      wrValidIn = 1'b1; wrDataIn = 8'h74;
      @(posedge clkIn);
      #2 rstIn = 1'b1;
      #1;
      tests_run++; if (levelOut !== 4'd0 || rdValidOut !== 1'b0 || wrReadyOut !== 1'b0 || rdDataOut !== 8'h00) begin
         tests_failed++; $display("FAIL async_rst got lvl %0d valid %b rdy %b data %h", levelOut, rdValidOut, wrReadyOut, rdDataOut); end
      tests_run++; if (almostEmptyOut !== 1'b1 || almostFullOut !== 1'b0) begin
         tests_failed++; $display("FAIL async_rst_almost got ae %b af %b want 1 0", almostEmptyOut, almostFullOut); end
      wrValidIn = 1'b0;
      model_reset();
      @(negedge clkIn); @(negedge clkIn);
      rstIn = 1'b0;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      tests_run++; if (rdDataOut !== 8'h99 || levelOut !== 4'd1) begin
         tests_failed++; $display("FAIL async_rst_recover got %h lvl %0d want 99 lvl 1", rdDataOut, levelOut); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_drain();
      test_level_one();
      test_flush();
      test_underflow();
      test_full_rw();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
